// File: rtl/sha256_round_core_if.sv
// Host-side bundle of the SHA-256 round core: message stream in, busy and chained hash out.
// EN qualifies idata32 and advances the core by one round per clock; there is no back-pressure, the core always accepts when EN=1 in IDLE/ROUND.
interface sha256_round_core_if;
    logic        init;
    logic        EN;
    logic [31:0] idata32;
    logic        busy;
    logic [31:0] Hash0;
    logic [31:0] Hash1;
    logic [31:0] Hash2;
    logic [31:0] Hash3;
    logic [31:0] Hash4;
    logic [31:0] Hash5;
    logic [31:0] Hash6;
    logic [31:0] Hash7;

    modport master (
        output init, EN, idata32,
        input  busy, Hash0, Hash1, Hash2, Hash3, Hash4, Hash5, Hash6, Hash7
    );

    modport slave (
        input  init, EN, idata32,
        output busy, Hash0, Hash1, Hash2, Hash3, Hash4, Hash5, Hash6, Hash7
    );
endinterface

// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression: one round per enabled clock, 16-word rolling schedule,
// chaining registers H updated only in the single FINAL cycle.
module sha256_round_core #(
    parameter int ROUNDS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    sha256_round_core_if.slave        bus,
    output logic [1:0]                state_dbg
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_FINAL = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [5:0]  rnd_q, rnd_d;
    logic [31:0] wk_q [8];
    logic [31:0] wk_d [8];
    logic [31:0] hash_q [8];
    logic [31:0] hash_d [8];
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    logic [31:0] src [8];
    logic [31:0] w_t;
    logic [31:0] t1;
    logic [31:0] t2;
    logic        run;

    // Round 0 is issued from IDLE and works on H directly; a same-cycle init substitutes the IV.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            src[i] = wk_q[i];
            if (state_q == S_IDLE) src[i] = bus.init ? IV[i] : hash_q[i];
        end
        w_t = (rnd_q < 6'd16) ? bus.idata32
                              : ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
        t1 = src[7] + bsig1(src[4]) + ((src[4] & src[5]) ^ (~src[4] & src[6])) + K_TAB[rnd_q] + w_t;
        t2 = bsig0(src[0]) + ((src[0] & src[1]) ^ (src[0] & src[2]) ^ (src[1] & src[2]));
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        rnd_d   = rnd_q;
        run     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wk_d[i]   = wk_q[i];
            hash_d[i] = hash_q[i];
        end
        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

        case (state_q)
            S_IDLE: begin
                if (bus.init) begin
                    for (int i = 0; i < 8; i++) hash_d[i] = IV[i];
                end
                if (bus.EN) begin
                    run     = 1'b1;
                    rnd_d   = 6'd1;
                    busy_d  = 1'b1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (bus.EN) begin
                    run = 1'b1;
                    if (rnd_q == LAST_RND) begin
                        rnd_d   = 6'd0;
                        state_d = S_FINAL;
                    end else begin
                        rnd_d = rnd_q + 6'd1;
                    end
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) hash_d[i] = hash_q[i] + wk_q[i];
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.init) begin
                    for (int i = 0; i < 8; i++) hash_d[i] = IV[i];
                end
                // The host may keep EN high briefly after busy falls; wait for it to drop.
                if (!bus.EN) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (run) begin
            wk_d[0] = t1 + t2;
            wk_d[1] = src[0];
            wk_d[2] = src[1];
            wk_d[3] = src[2];
            wk_d[4] = src[3] + t1;
            wk_d[5] = src[4];
            wk_d[6] = src[5];
            wk_d[7] = src[6];
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
            win_d[15] = w_t;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rnd_q   <= 6'd0;
            for (int i = 0; i < 8; i++) begin
                wk_q[i]   <= 32'd0;
                hash_q[i] <= IV[i];
            end
            for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            rnd_q   <= rnd_d;
            for (int i = 0; i < 8; i++) begin
                wk_q[i]   <= wk_d[i];
                hash_q[i] <= hash_d[i];
            end
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

    assign bus.busy  = busy_q;
    assign bus.Hash0 = hash_q[0];
    assign bus.Hash1 = hash_q[1];
    assign bus.Hash2 = hash_q[2];
    assign bus.Hash3 = hash_q[3];
    assign bus.Hash4 = hash_q[4];
    assign bus.Hash5 = hash_q[5];
    assign bus.Hash6 = hash_q[6];
    assign bus.Hash7 = hash_q[7];
    assign state_dbg = state_q;
endmodule

// File: tb/tb_sha256_round_core.sv
// Directed bench for sha256_round_core: block stimulus pushes expected digest and busy length,
// a negedge monitor pops and compares each time busy falls.
module tb_sha256_round_core;
  localparam logic [255:0] IV_CAT  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [1:0]   ST_IDLE = 2'd0;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  sha256_round_core_if bus ();

  sha256_round_core #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int n_vec;
  int n_fail;

  logic [255:0] exp_q [$];
  int           len_q [$];
  bit           chk_q [$];

  logic [31:0] abc_blk [16];
  logic [31:0] two_blk1 [16];
  logic [31:0] two_blk2 [16];

  function automatic logic [255:0] hash_cat();
    return {bus.Hash0, bus.Hash1, bus.Hash2, bus.Hash3, bus.Hash4, bus.Hash5, bus.Hash6, bus.Hash7};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // driver tasks
  task automatic stall(input int len);
    for (int i = 0; i < len; i++) begin
      bus.EN = 1'b0;
      bus.init = 1'b0;
      bus.idata32 = $urandom;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_block(input logic [31:0] blk [16], input logic [255:0] dig, input bit chk,
                           input bit init_start, input int st_a, input int len_a,
                           input int st_b, input int len_b, input int tail,
                           input bit init_done, input int init_rnd, input int rst_rnd);
    if (rst_rnd < 0) begin
      exp_q.push_back(dig);
      len_q.push_back(64 + ((st_a >= 0) ? len_a : 0) + ((st_b >= 0) ? len_b : 0));
      chk_q.push_back(chk);
    end
    for (int t = 0; t < 64; t++) begin
      if (t == st_a) stall(len_a);
      if (t == st_b) stall(len_b);
      if (t == rst_rnd) begin
        #1 rst = 1'b1;
        bus.EN = 1'b0;
        bus.init = 1'b0;
        #1;
        check("rst_busy", 256'(bus.busy), 256'(1'b0));
        check("rst_hash", hash_cat(), IV_CAT);
        check("rst_state", 256'(state_dbg), 256'(ST_IDLE));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      bus.EN = 1'b1;
      bus.idata32 = (t < 16) ? blk[t] : $urandom;
      bus.init = (t == 0 && init_start) || (t == init_rnd);
      @(posedge clk); #1;
    end
    bus.init = 1'b0;
    bus.idata32 = $urandom;
    bus.EN = (tail > 0);
    @(posedge clk); #1;
    for (int i = 0; i < tail; i++) begin
      bus.EN = 1'b1;
      bus.init = init_done && (i == 0);
      @(posedge clk); #1;
    end
    bus.EN = 1'b0;
    bus.init = 1'b0;
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  bit prev_busy;
  int busy_cnt;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (prev_busy && !bus.busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 256'(1), 256'(0));
        end else begin
          logic [255:0] e;
          int l;
          bit c;
          e = exp_q.pop_front();
          l = len_q.pop_front();
          c = chk_q.pop_front();
          check("busy_len", 256'(busy_cnt), 256'(l));
          if (c) check("digest", hash_cat(), e);
        end
        busy_cnt = 0;
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    n_vec = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) begin
      abc_blk[i] = 32'd0;
      two_blk2[i] = 32'd0;
    end
    abc_blk[0] = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    two_blk1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_blk2[15] = 32'h000001c0;

    rst = 1'b1;
    bus.EN = 1'b0;
    bus.init = 1'b0;
    bus.idata32 = 32'd0;
    #2;
    check("reset_busy", 256'(bus.busy), 256'(1'b0));
    check("reset_hash", hash_cat(), IV_CAT);
    check("reset_state", 256'(state_dbg), 256'(ST_IDLE));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // "abc", no stalls
    run_block(abc_blk, ABC_DIG, 1'b1, 1'b0, -1, 0, -1, 0, 0, 1'b0, -1, -1);

    // init alone in IDLE reloads IV
    bus.init = 1'b1;
    @(posedge clk); #1 bus.init = 1'b0;
    check("init_idle_hash", hash_cat(), IV_CAT);

    // "abc" with stalls at rnd 3 (1 cycle) and rnd 20 (5 cycles)
    run_block(abc_blk, ABC_DIG, 1'b1, 1'b0, 3, 1, 20, 5, 0, 1'b0, -1, -1);

    // H holds the abc digest: init+EN same cycle starts from IV; EN held 2 cycles after busy falls
    run_block(abc_blk, ABC_DIG, 1'b1, 1'b1, -1, 0, -1, 0, 2, 1'b0, -1, -1);
    for (int i = 0; i < 5; i++) begin
      check("no_restart_busy", 256'(bus.busy), 256'(1'b0));
      @(posedge clk); #1;
    end
    check("no_restart_hash", hash_cat(), ABC_DIG);
    check("no_restart_state", 256'(state_dbg), 256'(ST_IDLE));

    // init honoured in DONE
    run_block(abc_blk, ABC_DIG, 1'b1, 1'b1, -1, 0, -1, 0, 2, 1'b1, -1, -1);
    check("init_done_hash", hash_cat(), IV_CAT);

    // two-block message; init pulse during block 2 rounds must be ignored
    run_block(two_blk1, 256'd0, 1'b0, 1'b1, -1, 0, -1, 0, 0, 1'b0, -1, -1);
    run_block(two_blk2, TWO_DIG, 1'b1, 1'b0, -1, 0, -1, 0, 0, 1'b0, 40, -1);

    // reset mid-block at rnd 30, then a clean "abc"
    run_block(abc_blk, ABC_DIG, 1'b1, 1'b0, -1, 0, -1, 0, 0, 1'b0, -1, 30);
    run_block(abc_blk, ABC_DIG, 1'b1, 1'b0, -1, 0, -1, 0, 0, 1'b0, -1, -1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
